// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path.
// Holds the sequencer state encoding and the opcode constants that the
// fetch sequencer and the execute datapath both decode.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    OPER,
    EXEC,
    HALT
  } state_t;

  // Opcode lives in the top three bits of the instruction register.
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_BRZ = 3'b111;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, program memory and the datapath.
//   mem_req/mem_addr   : program-memory read request and address
//   mem_ack/mem_rdata  : read completion and data (valid when mem_ack=1)
//   ir_out/exec_valid  : instruction offered to the execute datapath
//   exec_ready         : datapath accepts/completes the instruction
// master = sequencer side, slave = memory/datapath side.
interface fetch_sequencer_if #(
  parameter int WIDTH = 8
) ();

  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] ir_out;
  logic             exec_valid;
  logic             exec_ready;

  modport master (
    output mem_req, mem_addr, ir_out, exec_valid,
    input  mem_ack, mem_rdata, exec_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir_out, exec_valid,
    output mem_ack, mem_rdata, exec_ready
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, loads RESET_VEC
//   i_load : load i_d (has priority over i_incr)
//   i_incr : increment by one, wrapping modulo 2^WIDTH
//   i_d    : value to load
//   o_q    : current PC
module pc_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_incr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_pc <= RESET_VEC;
    else if (i_load) r_pc <= i_d;
    else if (i_incr) r_pc <= r_pc + 1'b1;
  end

  assign o_q = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Control FSM of the 8-bit CPU: fetches instructions, decodes the opcode,
// fetches operands for JMP/BRZ, hands ALU instructions to the datapath and
// stops on HLT. Owns the PC (via pc_reg), changed only by increment or load.
//   clock, reset : clock and synchronous active-high reset
//   run          : start/continue, sampled at instruction boundaries
//   zero_flag    : datapath Z flag, used by BRZ
//   bus          : memory read port and execute handshake (master side)
//   pc_out       : current PC
//   halted       : HLT executed; only reset leaves this state
//   busy         : sequencer neither idle nor halted
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                zero_flag,
  fetch_sequencer_if.master   bus,
  output logic [WIDTH-1:0]    pc_out,
  output logic                halted,
  output logic                busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_ir;
  logic             r_mem_req;
  logic             r_exec_valid;
  logic             r_halted;
  logic             r_busy;
  logic [WIDTH-1:0] w_pc;
  logic             w_pc_load;
  logic             w_pc_incr;
  logic             w_ir_load;
  logic             w_ack;
  logic [2:0]       w_opcode;

  // An ack only counts while a request is actually outstanding.
  assign w_ack    = r_mem_req & bus.mem_ack;
  assign w_opcode = r_ir[WIDTH-1 -: 3];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_load   = 1'b0;
    w_pc_incr   = 1'b0;
    w_ir_load   = 1'b0;
    case (r_state)
      IDLE:   if (run) w_state_nxt = FETCH;
      FETCH:  if (w_ack) begin
                w_ir_load   = 1'b1;
                w_pc_incr   = 1'b1;
                w_state_nxt = DECODE;
              end
      DECODE: case (w_opcode)
                OP_HLT:         w_state_nxt = HALT;
                OP_JMP, OP_BRZ: w_state_nxt = OPER;
                default:        w_state_nxt = EXEC;
              endcase
      // Only JMP and BRZ reach OPER, so anything that is not BRZ is a JMP.
      OPER:   if (w_ack) begin
                if ((w_opcode != OP_BRZ) || zero_flag) w_pc_load = 1'b1;
                else                                   w_pc_incr = 1'b1;
                w_state_nxt = run ? FETCH : IDLE;
              end
      EXEC:   if (bus.exec_ready) w_state_nxt = run ? FETCH : IDLE;
      HALT:   w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so they line up with
  // the state they describe without any input-to-output combinational path.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ir         <= '0;
      r_mem_req    <= 1'b0;
      r_exec_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      if (w_ir_load) r_ir <= bus.mem_rdata;
      r_mem_req    <= (w_state_nxt == FETCH) || (w_state_nxt == OPER);
      r_exec_valid <= (w_state_nxt == EXEC);
      r_halted     <= (w_state_nxt == HALT);
      r_busy       <= (w_state_nxt != IDLE) && (w_state_nxt != HALT);
    end
  end

  pc_reg #(
    .WIDTH     (WIDTH),
    .RESET_VEC (RESET_VEC)
  ) u_pc (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_load (w_pc_load),
    .i_incr (w_pc_incr),
    .i_d    (bus.mem_rdata),
    .o_q    (w_pc)
  );

  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = w_pc;
  assign bus.ir_out     = r_ir;
  assign bus.exec_valid = r_exec_valid;
  assign pc_out         = w_pc;
  assign halted         = r_halted;
  assign busy           = r_busy;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic       run2;
  logic       zero_flag;
  logic       zf2;
  logic [7:0] pc_out;
  logic [7:0] pc2;
  logic       halted;
  logic       halted2;
  logic       busy;
  logic       busy2;

  fetch_sequencer_if #(.WIDTH(8)) bus ();
  fetch_sequencer_if #(.WIDTH(8)) bus2 ();

  fetch_sequencer #(.WIDTH(8), .RESET_VEC(8'h00)) dut (
    .clock(clock), .reset(reset), .run(run), .zero_flag(zero_flag),
    .bus(bus), .pc_out(pc_out), .halted(halted), .busy(busy)
  );

  fetch_sequencer #(.WIDTH(8), .RESET_VEC(8'hFF)) dut2 (
    .clock(clock), .reset(reset), .run(run2), .zero_flag(zf2),
    .bus(bus2), .pc_out(pc2), .halted(halted2), .busy(busy2)
  );

  always #5 clock = ~clock;

  logic [7:0]  mem [256];
  int unsigned ack_wait = 0;
  int unsigned wcnt;
  logic [8:0]  exp_addr_q[$];
  logic [8:0]  exp_ir_q[$];
  int          ack_cyc_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          sb_on = 1'b0;
  int          ev_count = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder and scoreboard monitor for the main DUT.
  initial begin
    logic [8:0] e;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    wcnt = 0;
    forever begin
      @(negedge clock);
      if (reset || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= ack_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
      if (sb_on) begin
        if (bus.mem_ack) begin
          e = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 9'h100;
          chk("mem_addr", {1'b0, bus.mem_addr}, e);
          ack_cyc_q.push_back(cyc);
        end
        if (bus.exec_valid) ev_count++;
        if (bus.exec_valid && bus.exec_ready) begin
          e = (exp_ir_q.size() != 0) ? exp_ir_q.pop_front() : 9'h100;
          chk("exec_ir", {1'b0, bus.ir_out}, e);
        end
      end
    end
  end

  // Second DUT: ack held high permanently (must be ignored without a request).
  initial begin
    forever begin
      @(negedge clock);
      bus2.mem_ack   = 1'b1;
      bus2.mem_rdata = (bus2.mem_addr == 8'hFF) ? 8'h21 : 8'h22;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic mem_fill();
    for (int i = 0; i < 256; i++) mem[i] = 8'h20;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    run2  = 1'b0;
    sb_on = 1'b0;
    tick(1);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_ev", bus.exec_valid, 0);
    chk("rst_halt", halted, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc_out, 8'h00);
    chk("rst_ir", bus.ir_out, 0);
    chk("rst_pc2", pc2, 8'hFF);
    exp_addr_q.delete();
    exp_ir_q.delete();
    ack_cyc_q.delete();
    ev_count = 0;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && (exp_addr_q.size() + exp_ir_q.size()) != 0; i++) tick(1);
    chk(tag, exp_addr_q.size() + exp_ir_q.size(), 0);
    sb_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; run2 = 1'b0; zero_flag = 1'b0; zf2 = 1'b0;
    bus.exec_ready = 1'b0; bus2.exec_ready = 1'b0;
    tick(2);

    // ALU instruction with exec stall, then next fetch at 01
    do_reset();
    mem_fill(); mem[0] = 8'h21; mem[1] = 8'h22;
    exp_addr_q.push_back(9'h000); exp_addr_q.push_back(9'h001);
    exp_ir_q.push_back(9'h021);
    sb_on = 1'b1; run = 1'b1;
    tick(3);
    chk("t1_ev", bus.exec_valid, 1);
    chk("t1_ir", bus.ir_out, 8'h21);
    chk("t1_req", bus.mem_req, 0);
    chk("t1_busy", busy, 1);
    chk("t1_pc", pc_out, 8'h01);
    tick(2);
    chk("t1_ev_hold", bus.exec_valid, 1);
    chk("t1_ir_hold", bus.ir_out, 8'h21);
    bus.exec_ready = 1'b1;
    wait_drain("t1_drain");

    // ALU latency with zero-wait memory and ready high
    do_reset();
    mem[2] = 8'h20;
    exp_addr_q.push_back(9'h000); exp_addr_q.push_back(9'h001); exp_addr_q.push_back(9'h002);
    exp_ir_q.push_back(9'h021); exp_ir_q.push_back(9'h022);
    sb_on = 1'b1; run = 1'b1;
    wait_drain("t1b_drain");
    chk("alu_lat0", ack_cyc_q[1] - ack_cyc_q[0], 3);
    chk("alu_lat1", ack_cyc_q[2] - ack_cyc_q[1], 3);

    // JMP
    do_reset();
    mem_fill(); mem[0] = 8'hC0; mem[1] = 8'h40;
    exp_addr_q.push_back(9'h000); exp_addr_q.push_back(9'h001); exp_addr_q.push_back(9'h040);
    sb_on = 1'b1; run = 1'b1;
    wait_drain("t2_drain");
    chk("jmp_no_ev", ev_count, 0);
    chk("jmp_oper_lat", ack_cyc_q[1] - ack_cyc_q[0], 2);
    chk("jmp_lat", ack_cyc_q[2] - ack_cyc_q[0], 3);
    chk("jmp_pc", pc_out, 8'h41);

    // BRZ taken
    do_reset();
    mem_fill(); mem[0] = 8'hE0; mem[1] = 8'h80;
    zero_flag = 1'b1;
    exp_addr_q.push_back(9'h000); exp_addr_q.push_back(9'h001); exp_addr_q.push_back(9'h080);
    sb_on = 1'b1; run = 1'b1;
    wait_drain("t3a_drain");
    chk("brz_t_pc", pc_out, 8'h81);
    chk("brz_t_no_ev", ev_count, 0);

    // BRZ not taken
    do_reset();
    zero_flag = 1'b0;
    exp_addr_q.push_back(9'h000); exp_addr_q.push_back(9'h001); exp_addr_q.push_back(9'h002);
    sb_on = 1'b1; run = 1'b1;
    wait_drain("t3b_drain");
    chk("brz_nt_pc", pc_out, 8'h03);
    chk("brz_nt_no_ev", ev_count, 0);

    // Operand fetch at FF wraps to 00
    do_reset();
    mem_fill(); mem[0] = 8'hC0; mem[1] = 8'hFF; mem[8'hFF] = 8'hE0;
    zero_flag = 1'b0;
    exp_addr_q.push_back(9'h000); exp_addr_q.push_back(9'h001); exp_addr_q.push_back(9'h0FF);
    exp_addr_q.push_back(9'h000); exp_addr_q.push_back(9'h001);
    sb_on = 1'b1; run = 1'b1;
    wait_drain("wrap_drain");
    chk("wrap_pc", pc_out, 8'h02);

    // Memory ack delayed three cycles
    do_reset();
    mem_fill(); mem[0] = 8'h21;
    ack_wait = 3;
    exp_addr_q.push_back(9'h000); exp_ir_q.push_back(9'h021);
    sb_on = 1'b1; run = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("wait_req", bus.mem_req, 1);
      chk("wait_addr", bus.mem_addr, 8'h00);
      chk("wait_ir", bus.ir_out, 8'h00);
    end
    @(posedge clock); #1;
    chk("wait_pc", pc_out, 8'h01);
    chk("wait_ir_ld", bus.ir_out, 8'h21);
    tick(1);
    chk("wait_pc_once", pc_out, 8'h01);
    chk("wait_ev", bus.exec_valid, 1);
    run = 1'b0;
    wait_drain("t4_drain");
    tick(2);
    chk("pause_busy", busy, 0);
    chk("pause_req", bus.mem_req, 0);
    chk("pause_pc", pc_out, 8'h01);
    ack_wait = 0;

    // RESET_VEC=FF, wrap to 00, pause after exec
    do_reset();
    bus2.exec_ready = 1'b0;
    run2 = 1'b1;
    tick(1);
    chk("rv_req", bus2.mem_req, 1);
    chk("rv_addr", bus2.mem_addr, 8'hFF);
    tick(1);
    chk("rv_pc_wrap", pc2, 8'h00);
    chk("rv_ir", bus2.ir_out, 8'h21);
    tick(1);
    chk("rv_ev", bus2.exec_valid, 1);
    run2 = 1'b0;
    tick(1);
    bus2.exec_ready = 1'b1;
    tick(1);
    chk("rv_idle_busy", busy2, 0);
    chk("rv_idle_req", bus2.mem_req, 0);
    chk("rv_idle_ev", bus2.exec_valid, 0);
    chk("rv_idle_pc", pc2, 8'h00);
    tick(3);
    chk("rv_ack_ignored_req", bus2.mem_req, 0);
    chk("rv_ack_ignored_pc", pc2, 8'h00);
    bus2.exec_ready = 1'b0;

    // HLT, run toggling ignored
    do_reset();
    mem_fill(); mem[0] = 8'h00;
    exp_addr_q.push_back(9'h000);
    sb_on = 1'b1; run = 1'b1;
    wait_drain("t6_drain");
    tick(2);
    chk("hlt_halted", halted, 1);
    chk("hlt_busy", busy, 0);
    chk("hlt_req", bus.mem_req, 0);
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      tick(1);
      chk("hlt_req_run", bus.mem_req, 0);
      chk("hlt_stay", halted, 1);
    end
    chk("hlt_pc", pc_out, 8'h01);

    // Reset during a FETCH wait
    do_reset();
    mem_fill();
    ack_wait = 10;
    run = 1'b1;
    tick(3);
    chk("midf_req", bus.mem_req, 1);
    reset = 1'b1;
    tick(1);
    chk("midf_rst_req", bus.mem_req, 0);
    chk("midf_rst_pc", pc_out, 8'h00);
    chk("midf_rst_busy", busy, 0);
    reset = 1'b0; run = 1'b0; ack_wait = 0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
